// File: rtl/ysyx_22050039_core_seq.sv
// Multi-cycle fetch/decode/exec/writeback sequencer owning the PC and instruction register.
// Optional performance counters are built when YSYX_22050039_PERF_CNT_EN is defined.
module ysyx_22050039_core_seq #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     INST_LEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned     TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ifu_req,
    output logic [XLEN-1:0]     ifu_addr,
    input  logic                ifu_valid,
    input  logic [INST_LEN-1:0] ifu_inst,
    output logic [INST_LEN-1:0] inst,
    input  logic [2:0]          func,
    input  logic                pc_wen,
    input  logic [XLEN-1:0]     pc_target,
    output logic [XLEN-1:0]     pc,
    output logic                reg_wen,
    output logic                halt,
    output logic [1:0]          halt_cause,
    output logic [63:0]         cycle_cnt,
    output logic [63:0]         instret
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_e;

    localparam logic [2:0]  FUNC_SD      = 3'd4;
    localparam logic [2:0]  FUNC_EBREAK  = 3'd6;
    localparam logic [2:0]  FUNC_INVALID = 3'd7;
    localparam logic [1:0]  CAUSE_EBREAK  = 2'b01;
    localparam logic [1:0]  CAUSE_INVALID = 2'b10;
    localparam logic [1:0]  CAUSE_TIMEOUT = 2'b11;
    localparam logic [31:0] WAIT_LAST     = 32'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic [INST_LEN-1:0] inst_q, inst_d;
    logic [31:0]         wait_q, wait_d;
    logic                store_q, store_d;
    logic [1:0]          cause_q, cause_d;

    // NOTE: every variable gets its hold value before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        wait_d  = wait_q;
        store_d = store_q;
        cause_d = cause_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                wait_d  = '0;
            end
            S_FETCH: begin
                // A valid in the final allowed wait cycle still wins over the timeout.
                if (ifu_valid) begin
                    inst_d  = ifu_inst;
                    state_d = S_DECODE;
                end else if (TIMEOUT != 0 && wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            S_DECODE: begin
                if (func == FUNC_EBREAK) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_EBREAK;
                end else if (func == FUNC_INVALID) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_INVALID;
                end else begin
                    state_d = S_EXEC;
                    store_d = (func == FUNC_SD);
                end
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                pc_d    = pc_wen ? pc_target : pc_q + XLEN'(4);
                state_d = S_FETCH;
                wait_d  = '0;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            wait_q  <= '0;
            store_q <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            wait_q  <= wait_d;
            store_q <= store_d;
            cause_q <= cause_d;
        end
    end

    // Store-ness is captured in DECODE so reg_wen depends on registers only.
    assign ifu_req    = (state_q == S_FETCH);
    assign ifu_addr   = pc_q;
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign reg_wen    = (state_q == S_WB) && !store_q;
    assign halt       = (state_q == S_HALT);
    assign halt_cause = cause_q;

`ifdef YSYX_22050039_PERF_CNT_EN
    logic [63:0] cycle_q, instret_q;
    logic        retire;

    // An ebreak retires in DECODE; everything else retires in WB.
    assign retire = (state_q == S_WB) || (state_q == S_DECODE && func == FUNC_EBREAK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != S_HALT) cycle_q <= cycle_q + 64'd1;
            if (retire)            instret_q <= instret_q + 64'd1;
        end
    end

    assign cycle_cnt = cycle_q;
    assign instret   = instret_q;
`else
    assign cycle_cnt = '0;
    assign instret   = '0;
`endif

endmodule
